// File: rtl/can_tx_scheduler.sv
// Transmit mailbox scheduler for one CAN node: lowest-ID-first selection, retry and abort tracking.
// Optional build macro CAN_SCHED_WATCHDOG_EN adds a WAIT-state timeout treated as arbitration loss.
module can_tx_scheduler #(
   parameter int NUM_MB      = 4,
   parameter int MAX_RETRY   = 3,
   parameter int TIMEOUT_CYC = 20000,
   localparam int IDX_W      = $clog2(NUM_MB)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mb_wr_en,
   input  logic [IDX_W-1:0]  mb_wr_idx,
   input  logic [10:0]       mb_wr_id,
   input  logic [3:0]        mb_wr_dlc,
   input  logic [63:0]       mb_wr_data,
   input  logic [NUM_MB-1:0] mb_abort,
   output logic [NUM_MB-1:0] mb_pending,
   output logic [NUM_MB-1:0] mb_done,
   output logic [NUM_MB-1:0] mb_err,
   output logic              mb_wr_rej,
   output logic              tx_req,
   output logic [10:0]       tx_id,
   output logic [3:0]        tx_dlc,
   output logic [63:0]       tx_data,
   input  logic              tx_done,
   input  logic              tx_arb_lost
);

   localparam int RTY_W = ($clog2(MAX_RETRY + 1) > 2) ? $clog2(MAX_RETRY + 1) : 2;

   if (NUM_MB < 2 || NUM_MB > 16 || MAX_RETRY < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("can_tx_scheduler: parameter out of range");
   end

   typedef enum logic [1:0] {S_IDLE, S_SELECT, S_REQ, S_WAIT} state_t;

   state_t             state_reg;
   logic [IDX_W-1:0]   cur_reg;
   logic               abort_def_reg;
   logic               tx_req_reg;
   logic [10:0]        tx_id_reg;
   logic [3:0]         tx_dlc_reg;
   logic [63:0]        tx_data_reg;
   logic               wr_rej_reg;

   logic [10:0]        id_reg    [NUM_MB];
   logic [3:0]         dlc_reg   [NUM_MB];
   logic [63:0]        data_reg  [NUM_MB];
   logic [RTY_W-1:0]   retry_reg [NUM_MB];
   logic [NUM_MB-1:0]  pending_reg;
   logic [NUM_MB-1:0]  done_reg;
   logic [NUM_MB-1:0]  err_reg;

   logic               in_flight;
   logic               wait_ok;
   logic               wait_fail;
   logic               drop;
   logic               wd_fire;
   logic               sel_found;
   logic [IDX_W-1:0]   sel_idx;
   logic [10:0]        sel_id;

   assign in_flight = (state_reg == S_REQ) || (state_reg == S_WAIT);
   assign wait_ok   = (state_reg == S_WAIT) && tx_done;
   assign wait_fail = (state_reg == S_WAIT) && !tx_done && (tx_arb_lost || wd_fire);
   // An abort seen while in flight turns any non-success outcome into a drop.
   assign drop      = wait_fail && (((int'(retry_reg[cur_reg]) + 1) >= MAX_RETRY)
                                    || abort_def_reg || mb_abort[cur_reg]);

   // Strict less-than keeps the lowest index on equal IDs.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      sel_id    = '1;
      for (int i = 0; i < NUM_MB; i++) begin
         if (pending_reg[i] && !mb_abort[i] && (!sel_found || id_reg[i] < sel_id)) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
            sel_id    = id_reg[i];
         end
      end
   end

   for (genvar gi = 0; gi < NUM_MB; gi++) begin : g_mb
      logic is_cur;
      logic load_ok;
      logic fsm_done;
      logic fsm_err;
      logic abort_now;

      assign is_cur    = (cur_reg == IDX_W'(gi));
      assign load_ok   = mb_wr_en && (mb_wr_idx == IDX_W'(gi)) && !pending_reg[gi];
      assign fsm_done  = wait_ok && is_cur;
      assign fsm_err   = drop && is_cur;
      assign abort_now = mb_abort[gi] && pending_reg[gi] && !(in_flight && is_cur);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            pending_reg[gi] <= 1'b0;
            done_reg[gi]    <= 1'b0;
            err_reg[gi]     <= 1'b0;
            retry_reg[gi]   <= '0;
            id_reg[gi]      <= '0;
            dlc_reg[gi]     <= '0;
            data_reg[gi]    <= '0;
         end else begin
            done_reg[gi] <= fsm_done;
            err_reg[gi]  <= fsm_err || abort_now;
            if (load_ok) begin
               pending_reg[gi] <= 1'b1;
               retry_reg[gi]   <= '0;
               id_reg[gi]      <= mb_wr_id;
               dlc_reg[gi]     <= (mb_wr_dlc > 4'd8) ? 4'd8 : mb_wr_dlc;
               data_reg[gi]    <= mb_wr_data;
            end else if (fsm_done || fsm_err || abort_now) begin
               pending_reg[gi] <= 1'b0;
               retry_reg[gi]   <= '0;
            end else if (wait_fail && is_cur) begin
               retry_reg[gi]   <= retry_reg[gi] + RTY_W'(1);
            end
         end
      end
   end

`ifdef CAN_SCHED_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] wd_cnt_reg;

   // Held at zero outside WAIT, so every WAIT entry starts a fresh count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wd_cnt_reg <= '0;
      else if (state_reg != S_WAIT || wd_fire)
         wd_cnt_reg <= '0;
      else
         wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
   end

   assign wd_fire = (state_reg == S_WAIT) && (wd_cnt_reg == WD_W'(TIMEOUT_CYC - 1));
`else
   assign wd_fire = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= S_IDLE;
         cur_reg       <= '0;
         abort_def_reg <= 1'b0;
         tx_req_reg    <= 1'b0;
         tx_id_reg     <= '0;
         tx_dlc_reg    <= '0;
         tx_data_reg   <= '0;
         wr_rej_reg    <= 1'b0;
      end else begin
         tx_req_reg <= 1'b0;
         wr_rej_reg <= mb_wr_en && pending_reg[mb_wr_idx];
         case (state_reg)
            S_IDLE: begin
               if (|pending_reg)
                  state_reg <= S_SELECT;
            end
            S_SELECT: begin
               if (sel_found) begin
                  cur_reg       <= sel_idx;
                  tx_id_reg     <= id_reg[sel_idx];
                  tx_dlc_reg    <= dlc_reg[sel_idx];
                  tx_data_reg   <= data_reg[sel_idx];
                  abort_def_reg <= 1'b0;
                  state_reg     <= S_REQ;
               end else begin
                  state_reg     <= S_IDLE;
               end
            end
            S_REQ: begin
               tx_req_reg    <= 1'b1;
               abort_def_reg <= abort_def_reg || mb_abort[cur_reg];
               state_reg     <= S_WAIT;
            end
            default: begin
               abort_def_reg <= abort_def_reg || mb_abort[cur_reg];
               if (tx_done)
                  state_reg <= S_IDLE;
               else if (wait_fail)
                  state_reg <= S_SELECT;
            end
         endcase
      end
   end

   assign mb_pending = pending_reg;
   assign mb_done    = done_reg;
   assign mb_err     = err_reg;
   assign mb_wr_rej  = wr_rej_reg;
   assign tx_req     = tx_req_reg;
   assign tx_id      = tx_id_reg;
   assign tx_dlc     = tx_dlc_reg;
   assign tx_data    = tx_data_reg;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Directed self-checking bench for can_tx_scheduler (4 mailboxes, 3 retries, 100-cycle watchdog when built in).
module tb_can_tx_scheduler;

   localparam int NUM_MB      = 4;
   localparam int MAX_RETRY   = 3;
   localparam int TIMEOUT_CYC = 100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mb_wr_en = 1'b0;
   logic [1:0]  mb_wr_idx = '0;
   logic [10:0] mb_wr_id = '0;
   logic [3:0]  mb_wr_dlc = '0;
   logic [63:0] mb_wr_data = '0;
   logic [3:0]  mb_abort = '0;
   logic [3:0]  mb_pending, mb_done, mb_err;
   logic        mb_wr_rej, tx_req;
   logic [10:0] tx_id;
   logic [3:0]  tx_dlc;
   logic [63:0] tx_data;
   logic        tx_done = 1'b0;
   logic        tx_arb_lost = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   can_tx_scheduler #(.NUM_MB(NUM_MB), .MAX_RETRY(MAX_RETRY), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .clk(clk), .rst_n(rst_n),
      .mb_wr_en(mb_wr_en), .mb_wr_idx(mb_wr_idx), .mb_wr_id(mb_wr_id),
      .mb_wr_dlc(mb_wr_dlc), .mb_wr_data(mb_wr_data), .mb_abort(mb_abort),
      .mb_pending(mb_pending), .mb_done(mb_done), .mb_err(mb_err), .mb_wr_rej(mb_wr_rej),
      .tx_req(tx_req), .tx_id(tx_id), .tx_dlc(tx_dlc), .tx_data(tx_data),
      .tx_done(tx_done), .tx_arb_lost(tx_arb_lost)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [1:0] idx, input logic [10:0] id, input logic [3:0] dlc,
                       input logic [63:0] data);
      mb_wr_en = 1'b1; mb_wr_idx = idx; mb_wr_id = id; mb_wr_dlc = dlc; mb_wr_data = data;
      cyc();
      mb_wr_en = 1'b0;
      $display("load mb%0d id=%h dlc=%0d", idx, id, dlc);
   endtask

   task automatic wait_req(input int max, output int n, output bit seen);
      n = 0;
      seen = 1'b0;
      forever begin
         if (tx_req === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (n >= max) break;
         cyc();
         n++;
      end
      if (seen) $display("tx_req id=%h dlc=%0d data=%h after %0d cycles", tx_id, tx_dlc, tx_data, n);
   endtask

   task automatic pulse_done();
      tx_done = 1'b1; cyc(); tx_done = 1'b0;
   endtask

   task automatic pulse_arb();
      tx_arb_lost = 1'b1; cyc(); tx_arb_lost = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) cyc();
      n_cmp++; if ({mb_pending, mb_done, mb_err, mb_wr_rej, tx_req, tx_id, tx_dlc} !== 29'd0) begin
         n_bad++; $display("FAIL reset_ctrl: got %h expected 0", {mb_pending, mb_done, mb_err, mb_wr_rej, tx_req, tx_id, tx_dlc}); end
      n_cmp++; if (tx_data !== 64'd0) begin
         n_bad++; $display("FAIL reset_data: got %h expected 0", tx_data); end
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_single();
      int n; bit seen;
      load(2'd0, 11'h1A1, 4'd8, 64'h0123456789ABCDEF);
      n_cmp++; if (mb_pending !== 4'b0001) begin n_bad++; $display("FAIL t1_pending_set: got %b expected 0001", mb_pending); end
      wait_req(10, n, seen);
      n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL t1_latency: got %0d expected 3", n); end
      n_cmp++; if (tx_id !== 11'h1A1) begin n_bad++; $display("FAIL t1_id: got %h expected 1a1", tx_id); end
      n_cmp++; if (tx_dlc !== 4'd8) begin n_bad++; $display("FAIL t1_dlc: got %0d expected 8", tx_dlc); end
      n_cmp++; if (tx_data !== 64'h0123456789ABCDEF) begin n_bad++; $display("FAIL t1_data: got %h expected 0123456789abcdef", tx_data); end
      cyc();
      n_cmp++; if (tx_req !== 1'b0) begin n_bad++; $display("FAIL t1_req_width: got %b expected 0", tx_req); end
      repeat (48) cyc();
      n_cmp++; if (tx_id !== 11'h1A1) begin n_bad++; $display("FAIL t1_id_hold: got %h expected 1a1", tx_id); end
      pulse_done();
      n_cmp++; if (mb_done !== 4'b0001) begin n_bad++; $display("FAIL t1_done: got %b expected 0001", mb_done); end
      n_cmp++; if (mb_pending !== 4'b0000) begin n_bad++; $display("FAIL t1_pending_clr: got %b expected 0000", mb_pending); end
      cyc();
      n_cmp++; if (mb_done !== 4'b0000) begin n_bad++; $display("FAIL t1_done_width: got %b expected 0000", mb_done); end
   endtask

   task automatic test_priority();
      int n; bit seen;
      logic [10:0] exp_id [3];
      logic [3:0]  exp_done [3];
      exp_id[0] = 11'h1A1; exp_id[1] = 11'h2B2; exp_id[2] = 11'h3C3;
      exp_done[0] = 4'b0100; exp_done[1] = 4'b0010; exp_done[2] = 4'b0001;
      load(2'd3, 11'h7FF, 4'd2, 64'hAA);
      wait_req(10, n, seen);
      n_cmp++; if (!seen) begin n_bad++; $display("FAIL t2_blocker_req: got none expected tx_req"); end
      load(2'd0, 11'h3C3, 4'd1, 64'h33);
      load(2'd1, 11'h2B2, 4'd2, 64'h22);
      load(2'd2, 11'h1A1, 4'd3, 64'h11);
      pulse_done();
      n_cmp++; if (mb_done !== 4'b1000) begin n_bad++; $display("FAIL t2_blocker_done: got %b expected 1000", mb_done); end
      for (int k = 0; k < 3; k++) begin
         wait_req(10, n, seen);
         n_cmp++; if (!seen || tx_id !== exp_id[k]) begin
            n_bad++; $display("FAIL t2_order%0d: got %h (seen=%0d) expected %h", k, tx_id, seen, exp_id[k]); end
         repeat (5) cyc();
         pulse_done();
         n_cmp++; if (mb_done !== exp_done[k]) begin
            n_bad++; $display("FAIL t2_done%0d: got %b expected %b", k, mb_done, exp_done[k]); end
      end
      n_cmp++; if (mb_pending !== 4'b0000) begin n_bad++; $display("FAIL t2_pending: got %b expected 0000", mb_pending); end
   endtask

   task automatic test_overtake();
      int n; bit seen;
      load(2'd1, 11'h100, 4'd4, 64'h1111);
      wait_req(10, n, seen);
      n_cmp++; if (!seen || tx_id !== 11'h100) begin n_bad++; $display("FAIL t3_first: got %h expected 100", tx_id); end
      load(2'd3, 11'h050, 4'd15, 64'h5050);
      pulse_arb();
      n_cmp++; if (mb_err !== 4'b0000 || mb_pending !== 4'b1010) begin
         n_bad++; $display("FAIL t3_after_lost: got err=%b pend=%b expected err=0000 pend=1010", mb_err, mb_pending); end
      wait_req(10, n, seen);
      n_cmp++; if (!seen || tx_id !== 11'h050) begin n_bad++; $display("FAIL t3_overtake: got %h expected 050", tx_id); end
      n_cmp++; if (tx_dlc !== 4'd8) begin n_bad++; $display("FAIL t3_dlc_clamp: got %0d expected 8", tx_dlc); end
      n_cmp++; if (tx_data !== 64'h5050) begin n_bad++; $display("FAIL t3_data: got %h expected 5050", tx_data); end
      pulse_done();
      n_cmp++; if (mb_done !== 4'b1000) begin n_bad++; $display("FAIL t3_done3: got %b expected 1000", mb_done); end
      wait_req(10, n, seen);
      n_cmp++; if (!seen || tx_id !== 11'h100) begin n_bad++; $display("FAIL t3_resend: got %h expected 100", tx_id); end
      pulse_done();
      n_cmp++; if (mb_done !== 4'b0010) begin n_bad++; $display("FAIL t3_done1: got %b expected 0010", mb_done); end
   endtask

   task automatic test_retry();
      int n; bit seen;
      int reqs = 0;
      load(2'd0, 11'h123, 4'd2, 64'h77);
      for (int r = 0; r < MAX_RETRY; r++) begin
         wait_req(10, n, seen);
         if (seen) reqs++;
         pulse_arb();
         n_cmp++; if (mb_err !== ((r == MAX_RETRY - 1) ? 4'b0001 : 4'b0000)) begin
            n_bad++; $display("FAIL t4_err%0d: got %b expected %b", r, mb_err, (r == MAX_RETRY - 1) ? 4'b0001 : 4'b0000); end
         n_cmp++; if (mb_pending !== ((r == MAX_RETRY - 1) ? 4'b0000 : 4'b0001)) begin
            n_bad++; $display("FAIL t4_pend%0d: got %b expected %b", r, mb_pending, (r == MAX_RETRY - 1) ? 4'b0000 : 4'b0001); end
      end
      wait_req(10, n, seen);
      if (seen) reqs++;
      n_cmp++; if (reqs !== MAX_RETRY) begin n_bad++; $display("FAIL t4_req_count: got %0d expected %0d", reqs, MAX_RETRY); end
   endtask

   task automatic test_reject_abort();
      int n; bit seen;
      load(2'd2, 11'h222, 4'd1, 64'h2222);
      load(2'd2, 11'h0AA, 4'd3, 64'hAAAA);
      n_cmp++; if (mb_wr_rej !== 1'b1) begin n_bad++; $display("FAIL t5_rej: got %b expected 1", mb_wr_rej); end
      cyc();
      n_cmp++; if (mb_wr_rej !== 1'b0) begin n_bad++; $display("FAIL t5_rej_width: got %b expected 0", mb_wr_rej); end
      wait_req(10, n, seen);
      n_cmp++; if (!seen || tx_id !== 11'h222 || tx_dlc !== 4'd1) begin
         n_bad++; $display("FAIL t5_orig_kept: got id=%h dlc=%0d expected id=222 dlc=1", tx_id, tx_dlc); end
      load(2'd1, 11'h300, 4'd2, 64'h3000);
      mb_abort = 4'b0010; cyc(); mb_abort = 4'b0000;
      n_cmp++; if (mb_err !== 4'b0010 || mb_pending !== 4'b0100) begin
         n_bad++; $display("FAIL t5_abort_idle: got err=%b pend=%b expected err=0010 pend=0100", mb_err, mb_pending); end
      pulse_done();
      n_cmp++; if (mb_done !== 4'b0100) begin n_bad++; $display("FAIL t5_done2: got %b expected 0100", mb_done); end
      load(2'd0, 11'h010, 4'd2, 64'h0101);
      wait_req(10, n, seen);
      mb_abort = 4'b0001;
      repeat (3) cyc();
      n_cmp++; if (mb_err !== 4'b0000 || mb_pending !== 4'b0001) begin
         n_bad++; $display("FAIL t5_abort_deferred: got err=%b pend=%b expected err=0000 pend=0001", mb_err, mb_pending); end
      pulse_done();
      n_cmp++; if (mb_done !== 4'b0001 || mb_err !== 4'b0000) begin
         n_bad++; $display("FAIL t5_abort_inflight: got done=%b err=%b expected done=0001 err=0000", mb_done, mb_err); end
      mb_abort = 4'b0000;
      cyc();
      n_cmp++; if (mb_pending !== 4'b0000) begin n_bad++; $display("FAIL t5_pending: got %b expected 0000", mb_pending); end
   endtask

   task automatic test_reset_mid_frame();
      int n; bit seen;
      load(2'd1, 11'h155, 4'd5, 64'hDEAD);
      wait_req(10, n, seen);
      repeat (2) cyc();
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if ({mb_pending, mb_done, mb_err, mb_wr_rej, tx_req, tx_id, tx_dlc} !== 29'd0 || tx_data !== 64'd0) begin
         n_bad++; $display("FAIL t6_async_reset: got id=%h pend=%b data=%h expected all 0", tx_id, mb_pending, tx_data); end
      cyc();
      rst_n = 1'b1;
      cyc();
      wait_req(10, n, seen);
      n_cmp++; if (seen || mb_pending !== 4'b0000) begin
         n_bad++; $display("FAIL t6_discard: got req=%0d pend=%b expected req=0 pend=0000", seen, mb_pending); end
   endtask

`ifdef CAN_SCHED_WATCHDOG_EN
   task automatic test_watchdog();
      int n; bit seen; int k;
      load(2'd0, 11'h0F0, 4'd1, 64'hF0);
      wait_req(10, n, seen);
      for (int r = 1; r < MAX_RETRY; r++) begin
         cyc();
         wait_req(200, n, seen);
         n_cmp++; if (!seen || n + 1 !== 102) begin
            n_bad++; $display("FAIL t7_period%0d: got %0d expected 102", r, n + 1); end
      end
      k = 0;
      while (mb_err === 4'b0000 && k < 200) begin cyc(); k++; end
      n_cmp++; if (k !== 100 || mb_err !== 4'b0001) begin
         n_bad++; $display("FAIL t7_err: got err=%b at %0d expected 0001 at 100", mb_err, k); end
      n_cmp++; if (mb_pending !== 4'b0000) begin n_bad++; $display("FAIL t7_pending: got %b expected 0000", mb_pending); end
   endtask
`endif

   initial begin
      #1;
      test_reset();
      test_single();
      test_priority();
      test_overtake();
      test_retry();
      test_reject_abort();
`ifdef CAN_SCHED_WATCHDOG_EN
      test_watchdog();
`endif
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: got no completion expected finish before 1000000");
      $fatal(1, "bench timeout");
   end

endmodule
